writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Writeback stage between execute/memory and the 16-entry register file (x0..x15).
//  Accepts ALU results and load requests and waits for the memory response on loads.
//  Aligns and sign/zero-extends load data, then drives the register file write port (regwen/rd/data).
//  Exposes a pending-load tag so the hazard logic can stall dependent reads.
// PARAMETERS
//  LOAD_TIMEOUT  16  cycles to wait in WAIT_LOAD for I_mem_rvalid before aborting; legal range 1..255
// PORTS
//  I_clk           in   1   clock, all logic on posedge
//  I_rst_n         in   1   synchronous reset, active-low
//  I_valid         in   1   execute presents an instruction result this cycle
//  O_ready         out  1   stage can accept; an instruction is taken when I_valid && O_ready
//  I_rd            in   4   destination register index
//  I_alu_result    in   32  ALU result; for loads, this is the byte address (bits [1:0] select the lane)
//  I_is_load       in   1   instruction is a load
//  I_funct3        in   3   load width: 0=LB 1=LH 2=LW 4=LBU 5=LHU; 3/6/7 illegal
//  I_mem_rvalid    in   1   data memory read response valid
//  I_mem_rdata     in   32  data memory read word, little-endian
//  O_regwen        out  1   register file write enable
//  O_rd            out  4   register file write index
//  O_data          out  32  register file write data
//  O_pending       out  1   a load is outstanding (state WAIT_LOAD)
//  O_pending_rd    out  4   rd of the outstanding load
//  O_misaligned    out  1   one-cycle pulse: misaligned load rejected
//  O_illegal       out  1   one-cycle pulse: illegal funct3 on a load rejected
//  O_timeout       out  1   one-cycle pulse: load aborted after LOAD_TIMEOUT cycles
// BEHAVIOUR
//  Reset (I_rst_n=0 at posedge):
//   - State returns to IDLE; any outstanding load is dropped and never written.
//   - All outputs are 0, except O_ready=1 from the first cycle after reset.
//  States:
//   - IDLE: O_ready=1.
//   - WAIT_LOAD: O_ready=0, O_pending=1, O_pending_rd=latched rd.
//  Accepting a non-load in IDLE:
//   - Next cycle: O_regwen=1, O_rd=I_rd, O_data=I_alu_result for exactly one cycle.
//   - Latency is 1. Back-to-back accepts are allowed each cycle.
//  Accepting a load in IDLE:
//   - Latch rd, funct3 and addr[1:0]; go to WAIT_LOAD and clear the timeout counter.
//   - Checks are made at accept time:
//     - Illegal funct3 -> O_illegal pulse next cycle; stay in IDLE; no write.
//     - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> O_misaligned pulse next cycle; stay in IDLE; no write.
//     - When both apply, only O_illegal pulses.
//  WAIT_LOAD:
//   - Counter increments each cycle with I_mem_rvalid=0.
//   - On I_mem_rvalid: extract the lane and go to IDLE; the next cycle drives O_regwen=1 with the result (rvalid to write is 1 cycle).
//     - LB/LBU: byte = rdata[8*addr+7 : 8*addr]
//     - LH/LHU: half = rdata[16*addr[1]+15 : 16*addr[1]]
//     - LW: full word
//     - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
//   - On counter reaching LOAD_TIMEOUT with no rvalid: O_timeout pulse next cycle; go to IDLE; no write.
//   - rvalid in the same cycle the counter expires: rvalid wins, the write happens, no timeout.
//  rd==0 (either path): result is computed but O_regwen stays 0; status pulses still fire.
//  I_mem_rvalid while in IDLE: ignored.
//  I_valid while in WAIT_LOAD: not accepted; upstream must hold its inputs.
//  O_regwen, O_misaligned, O_illegal and O_timeout are registered and never assert two cycles in a row for the same instruction.
// TESTING
//  1. Reset then ALU op: rd=5, alu=0xDEADBEEF -> one cycle later O_regwen=1, O_rd=5, O_data=0xDEADBEEF; next cycle O_regwen=0.
//  2. LB at addr 0x...3, rdata=0x80112233, rvalid 3 cycles later -> O_pending=1, O_ready=0 while waiting; write O_data=0xFFFFFF80.
//     Repeat with LBU -> O_data=0x00000080.
//  3. LH at addr 0x...2, rdata=0x8001ABCD -> O_data=0xFFFF8001. LHU at addr 0x...1 -> O_misaligned pulse, O_regwen stays 0, O_ready stays 1.
//  4. LW, no rvalid -> O_timeout pulses after 16 wait cycles, no write.
//     LW with rvalid on the 16th wait cycle -> write, O_timeout stays 0.
//  5. Load to rd=0 with rvalid -> no O_regwen. I_funct3=3 -> O_illegal pulse.
//     Stray I_mem_rvalid in IDLE -> no effect.
//  6. Reset asserted in WAIT_LOAD, rvalid arriving the cycle after reset -> no write, O_pending=0, O_ready=1.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results and loads into the x0..x15 register file.
// Loads wait for the memory response, are lane-aligned and extended, then written.
module writeback_unit #(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic [3:0]  I_rd,
    input  logic [31:0] I_alu_result,
    input  logic        I_is_load,
    input  logic [2:0]  I_funct3,
    input  logic        I_mem_rvalid,
    input  logic [31:0] I_mem_rdata,
    output logic        O_regwen,
    output logic [3:0]  O_rd,
    output logic [31:0] O_data,
    output logic        O_pending,
    output logic [3:0]  O_pending_rd,
    output logic        O_misaligned,
    output logic        O_illegal,
    output logic        O_timeout
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  prd_q, prd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        regwen_q, regwen_d;
    logic [3:0]  wrd_q, wrd_d;
    logic [31:0] data_q, data_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;
    logic        tmo_q, tmo_d;

    logic        accept;
    logic        f3_bad;
    logic        addr_bad;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    assign accept = I_valid && (state_q == S_IDLE);

    // Load legality and alignment, evaluated on the incoming instruction
    always_comb begin
        f3_bad   = (I_funct3 == 3'd3) || (I_funct3 == 3'd6) || (I_funct3 == 3'd7);
        addr_bad = ((I_funct3[1:0] == 2'd1) && I_alu_result[0])
                || ((I_funct3 == 3'd2) && (I_alu_result[1:0] != 2'd0));
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        shifted = I_mem_rdata >> {lane_q, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = lane_q[1] ? I_mem_rdata[31:16] : I_mem_rdata[15:0];
        unique case (f3_q)
            3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
            3'd4:    load_val = {24'd0, lane_b};
            3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
            3'd5:    load_val = {16'd0, lane_h};
            default: load_val = I_mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        prd_d    = prd_q;
        f3_d     = f3_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        regwen_d = 1'b0;
        wrd_d    = wrd_q;
        data_d   = data_q;
        mis_d    = 1'b0;
        ill_d    = 1'b0;
        tmo_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!I_is_load) begin
                        regwen_d = (I_rd != 4'd0);
                        wrd_d    = I_rd;
                        data_d   = I_alu_result;
                    end else if (f3_bad) begin
                        ill_d = 1'b1;
                    end else if (addr_bad) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        prd_d   = I_rd;
                        f3_d    = I_funct3;
                        lane_d  = I_alu_result[1:0];
                        cnt_d   = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                if (I_mem_rvalid) begin
                    state_d  = S_IDLE;
                    regwen_d = (prd_q != 4'd0);
                    wrd_d    = prd_q;
                    data_d   = load_val;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q  <= S_IDLE;
            prd_q    <= 4'd0;
            f3_q     <= 3'd0;
            lane_q   <= 2'd0;
            cnt_q    <= 8'd0;
            regwen_q <= 1'b0;
            wrd_q    <= 4'd0;
            data_q   <= 32'd0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prd_q    <= prd_d;
            f3_q     <= f3_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            regwen_q <= regwen_d;
            wrd_q    <= wrd_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            tmo_q    <= tmo_d;
        end
    end

    assign O_ready      = (state_q == S_IDLE);
    assign O_pending    = (state_q == S_WAIT);
    assign O_pending_rd = O_pending ? prd_q : 4'd0;
    assign O_regwen     = regwen_q;
    assign O_rd         = wrd_q;
    assign O_data       = data_q;
    assign O_misaligned = mis_q;
    assign O_illegal    = ill_q;
    assign O_timeout    = tmo_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU path, load extension, status pulses,
// timeout boundary and reset during an outstanding load.
module tb_writeback_unit;

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic        I_valid;
    logic        O_ready;
    logic [3:0]  I_rd;
    logic [31:0] I_alu_result;
    logic        I_is_load;
    logic [2:0]  I_funct3;
    logic        I_mem_rvalid;
    logic [31:0] I_mem_rdata;
    logic        O_regwen;
    logic [3:0]  O_rd;
    logic [31:0] O_data;
    logic        O_pending;
    logic [3:0]  O_pending_rd;
    logic        O_misaligned;
    logic        O_illegal;
    logic        O_timeout;

    int n_chk = 0;
    int n_fail = 0;

    writeback_unit #(.LOAD_TIMEOUT(16)) dut (
        .I_clk        (I_clk),
        .I_rst_n      (I_rst_n),
        .I_valid      (I_valid),
        .O_ready      (O_ready),
        .I_rd         (I_rd),
        .I_alu_result (I_alu_result),
        .I_is_load    (I_is_load),
        .I_funct3     (I_funct3),
        .I_mem_rvalid (I_mem_rvalid),
        .I_mem_rdata  (I_mem_rdata),
        .O_regwen     (O_regwen),
        .O_rd         (O_rd),
        .O_data       (O_data),
        .O_pending    (O_pending),
        .O_pending_rd (O_pending_rd),
        .O_misaligned (O_misaligned),
        .O_illegal    (O_illegal),
        .O_timeout    (O_timeout)
    );

    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] rd, input logic [31:0] v);
        I_valid      = 1'b1;
        I_is_load    = 1'b0;
        I_rd         = rd;
        I_alu_result = v;
        tick();
        I_valid = 1'b0;
        check("alu_wen", O_regwen, 1'b1);
        check("alu_rd", O_rd, rd);
        check("alu_data", O_data, v);
    endtask

    task automatic load(input string tag, input logic [3:0] rd,
                        input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] rdata, input int gap,
                        input logic exp_wen, input logic [31:0] exp_data);
        I_valid      = 1'b1;
        I_is_load    = 1'b1;
        I_rd         = rd;
        I_alu_result = addr;
        I_funct3     = f3;
        tick();
        I_valid = 1'b0;
        check({tag, "_pend"}, O_pending, 1'b1);
        check({tag, "_rdy"}, O_ready, 1'b0);
        check({tag, "_prd"}, O_pending_rd, rd);
        for (int i = 0; i < gap; i++) tick();
        check({tag, "_wait_wen"}, O_regwen, 1'b0);
        I_mem_rvalid = 1'b1;
        I_mem_rdata  = rdata;
        tick();
        I_mem_rvalid = 1'b0;
        check({tag, "_wen"}, O_regwen, exp_wen);
        check({tag, "_tmo"}, O_timeout, 1'b0);
        check({tag, "_idle"}, O_ready, 1'b1);
        if (exp_wen) begin
            check({tag, "_rd"}, O_rd, rd);
            check({tag, "_data"}, O_data, exp_data);
        end
        tick();
        check({tag, "_wen_off"}, O_regwen, 1'b0);
    endtask

    task automatic reject(input string tag, input logic [2:0] f3,
                          input logic [31:0] addr, input logic exp_mis,
                          input logic exp_ill);
        I_valid      = 1'b1;
        I_is_load    = 1'b1;
        I_rd         = 4'd7;
        I_alu_result = addr;
        I_funct3     = f3;
        tick();
        I_valid = 1'b0;
        check({tag, "_mis"}, O_misaligned, exp_mis);
        check({tag, "_ill"}, O_illegal, exp_ill);
        check({tag, "_wen"}, O_regwen, 1'b0);
        check({tag, "_rdy"}, O_ready, 1'b1);
        check({tag, "_pend"}, O_pending, 1'b0);
        tick();
        check({tag, "_mis_off"}, O_misaligned, 1'b0);
        check({tag, "_ill_off"}, O_illegal, 1'b0);
    endtask

    initial begin
        I_rst_n      = 1'b0;
        I_valid      = 1'b0;
        I_rd         = 4'd0;
        I_alu_result = 32'd0;
        I_is_load    = 1'b0;
        I_funct3     = 3'd0;
        I_mem_rvalid = 1'b0;
        I_mem_rdata  = 32'd0;
        tick();
        tick();
        check("rst_wen", O_regwen, 1'b0);
        check("rst_pend", O_pending, 1'b0);
        check("rst_flags", {O_misaligned, O_illegal, O_timeout}, 3'b000);
        check("rst_data", O_data, 32'd0);
        I_rst_n = 1'b1;
        check("rst_ready", O_ready, 1'b1);

        alu_op(4'd5, 32'hDEADBEEF);
        tick();
        check("alu_wen_off", O_regwen, 1'b0);
        alu_op(4'd1, 32'h0000_0011);
        alu_op(4'd2, 32'h0000_0022);
        I_rd         = 4'd0;
        I_valid      = 1'b1;
        I_is_load    = 1'b0;
        I_alu_result = 32'h1234_5678;
        tick();
        I_valid = 1'b0;
        check("alu_x0_wen", O_regwen, 1'b0);
        tick();

        load("lb", 4'd3, 32'h0000_1003, 3'd0, 32'h8011_2233, 2, 1'b1, 32'hFFFF_FF80);
        load("lbu", 4'd4, 32'h0000_1003, 3'd4, 32'h8011_2233, 2, 1'b1, 32'h0000_0080);
        load("lb1", 4'd6, 32'h0000_1001, 3'd0, 32'h8011_2233, 0, 1'b1, 32'h0000_0022);
        load("lh", 4'd8, 32'h0000_2002, 3'd1, 32'h8001_ABCD, 1, 1'b1, 32'hFFFF_8001);
        load("lhu", 4'd9, 32'h0000_2002, 3'd5, 32'h8001_ABCD, 1, 1'b1, 32'h0000_8001);
        load("lh0", 4'd10, 32'h0000_2000, 3'd1, 32'h8001_ABCD, 0, 1'b1, 32'hFFFF_ABCD);
        load("lw", 4'd11, 32'h0000_3000, 3'd2, 32'hCAFE_F00D, 0, 1'b1, 32'hCAFE_F00D);

        reject("lhu_mis", 3'd5, 32'h0000_2001, 1'b1, 1'b0);
        reject("lw_mis", 3'd2, 32'h0000_3002, 1'b1, 1'b0);
        reject("f3_ill", 3'd3, 32'h0000_0000, 1'b0, 1'b1);
        reject("f3_ill_odd", 3'd6, 32'h0000_0003, 1'b0, 1'b1);

        // LW with no response: 16 wait cycles then a timeout pulse
        I_valid      = 1'b1;
        I_is_load    = 1'b1;
        I_rd         = 4'd12;
        I_alu_result = 32'h0000_4000;
        I_funct3     = 3'd2;
        tick();
        I_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("tmo_still_pend", O_pending, 1'b1);
        check("tmo_early", O_timeout, 1'b0);
        tick();
        check("tmo_pulse", O_timeout, 1'b1);
        check("tmo_wen", O_regwen, 1'b0);
        check("tmo_idle", O_ready, 1'b1);
        tick();
        check("tmo_off", O_timeout, 1'b0);

        // rvalid on the 16th wait cycle wins over expiry
        load("lw_edge", 4'd13, 32'h0000_4000, 3'd2, 32'h0BAD_BEEF, 15, 1'b1, 32'h0BAD_BEEF);

        load("ld_x0", 4'd0, 32'h0000_0000, 3'd2, 32'h1111_2222, 1, 1'b0, 32'd0);

        // Stray response while idle
        I_mem_rvalid = 1'b1;
        I_mem_rdata  = 32'hFFFF_FFFF;
        tick();
        I_mem_rvalid = 1'b0;
        check("stray_wen", O_regwen, 1'b0);
        check("stray_pend", O_pending, 1'b0);
        check("stray_rdy", O_ready, 1'b1);

        // Reset while a load is outstanding
        I_valid      = 1'b1;
        I_is_load    = 1'b1;
        I_rd         = 4'd14;
        I_alu_result = 32'h0000_5000;
        I_funct3     = 3'd2;
        tick();
        I_valid = 1'b0;
        check("rstw_pend", O_pending, 1'b1);
        I_rst_n = 1'b0;
        tick();
        I_rst_n      = 1'b1;
        I_mem_rvalid = 1'b1;
        I_mem_rdata  = 32'h5555_AAAA;
        tick();
        I_mem_rvalid = 1'b0;
        check("rstw_wen", O_regwen, 1'b0);
        check("rstw_pend0", O_pending, 1'b0);
        check("rstw_rdy", O_ready, 1'b1);
        check("rstw_prd", O_pending_rd, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
